// File: rtl/jac_pkg.sv
// ============================================================================
// Module : jac_pkg
// Brief  : Shared widths, flow-control opcodes and FSM state type for the
//          branch unit and its return stack.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jac_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int STACK_DEPTH = 4;

    localparam logic [3:0] c_OP_GOTO = 4'hA;
    localparam logic [3:0] c_OP_BR   = 4'hB;
    localparam logic [3:0] c_OP_BRZ  = 4'hC;
    localparam logic [3:0] c_OP_BRC  = 4'hD;
    localparam logic [3:0] c_OP_CALL = 4'hE;
    localparam logic [3:0] c_OP_RET  = 4'hF;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    // Opcodes A..F change control flow; everything below is handed to execute.
    function automatic logic is_flow(input logic [3:0] op);
        return (op >= c_OP_GOTO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/return_stack.sv
// ============================================================================
// Module : return_stack
// Brief  : Circular return-address stack; a push when full overwrites the
//          oldest entry, a pop when empty is ignored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;

    // Pointer wraps explicitly so non-power-of-two depths stay circular.
    always_comb begin
        w_ptr_inc = (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        w_ptr_dec = (r_wr_ptr == '0) ? c_PTR_W'(DEPTH - 1) : r_wr_ptr - 1'b1;
    end

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_top   = r_mem[w_ptr_dec];

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_push) begin
            r_wr_ptr <= w_ptr_inc;
            if (!o_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && !o_empty) begin
            r_wr_ptr <= w_ptr_dec;
            r_count  <= r_count - 1'b1;
        end
    end

    // Entry storage needs no reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (res_n && i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// Module : branch_unit
// Brief  : Zero-cycle flow-control decode with one-slot squash after taken
//          jumps, return stack, and instruction register for execute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_unit #(
    parameter int PC_WIDTH    = jac_pkg::PC_WIDTH,
    parameter int STACK_DEPTH = jac_pkg::STACK_DEPTH
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [15:0]         instr,
    input  logic                flag_z,
    input  logic                flag_c,
    output logic                wr_en,
    output logic                add_offset,
    output logic [PC_WIDTH-1:0] counteradress,
    output logic [15:0]         ir,
    output logic                ir_valid,
    output logic                stack_err
);

    import jac_pkg::*;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]          w_op;
    logic [PC_WIDTH-1:0] w_field;
    logic                w_run;
    logic                w_take;
    logic                w_rel;
    logic [PC_WIDTH-1:0] w_tgt;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;
    logic                w_load_ir;

    logic [PC_WIDTH-1:0] w_stk_top;
    logic                w_stk_full;
    logic                w_stk_empty;

    assign w_op    = instr[15:12];
    assign w_field = PC_WIDTH'(instr[7:0]);
    // Reset gates the decode so outputs are quiet while res_n is low.
    assign w_run   = res_n && (r_state == ST_RUN);

    always_comb begin
        w_take    = 1'b0;
        w_rel     = 1'b0;
        w_tgt     = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        w_load_ir = 1'b0;
        if (w_run) begin
            case (w_op)
                c_OP_GOTO: begin
                    w_take = 1'b1;
                    w_tgt  = w_field;
                end
                c_OP_BR: begin
                    w_take = 1'b1;
                    w_rel  = 1'b1;
                    w_tgt  = w_field;
                end
                c_OP_BRZ: begin
                    w_take = flag_z;
                    w_rel  = flag_z;
                    w_tgt  = flag_z ? w_field : '0;
                end
                c_OP_BRC: begin
                    w_take = flag_c;
                    w_rel  = flag_c;
                    w_tgt  = flag_c ? w_field : '0;
                end
                c_OP_CALL: begin
                    w_take    = 1'b1;
                    w_tgt     = w_field;
                    w_push    = 1'b1;
                    w_err_set = w_stk_full;
                end
                c_OP_RET: begin
                    if (w_stk_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_take = 1'b1;
                        w_tgt  = w_stk_top;
                        w_pop  = 1'b1;
                    end
                end
                default: begin
                    w_load_ir = !is_flow(w_op);
                end
            endcase
        end
    end

    always_comb begin
        wr_en         = w_take;
        add_offset    = w_take & w_rel;
        counteradress = w_take ? w_tgt : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN:    w_state_nxt = w_take ? ST_SQUASH : ST_RUN;
            ST_SQUASH: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state   <= ST_BOOT;
            ir        <= 16'h0000;
            ir_valid  <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            ir_valid <= w_load_ir;
            if (w_load_ir) begin
                ir <= instr;
            end
            if (w_err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    // The pushed return address is the live pc, i.e. the word after the CALL.
    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk     (clk),
        .res_n   (res_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (pc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module : tb_branch_unit
// Brief  : Bench for branch_unit: program memory plus PC register around the
//          DUT, a queue-based reference model and directed program scenarios.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [7:0]  pc = 8'hFF;
    logic [15:0] instr = 16'hA055;
    logic        flag_z = 1'b0;
    logic        flag_c = 1'b0;
    logic        wr_en;
    logic        add_offset;
    logic [7:0]  counteradress;
    logic [15:0] ir;
    logic        ir_valid;
    logic        stack_err;

    always #5 clk = ~clk;

    branch_unit #(
        .PC_WIDTH    (8),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .res_n         (res_n),
        .pc            (pc),
        .instr         (instr),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .wr_en         (wr_en),
        .add_offset    (add_offset),
        .counteradress (counteradress),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .stack_err     (stack_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [15:0] mem [256];

    // Values sampled at the negedge of the most recent cycle.
    logic        s_wr, s_ao, s_irv, s_err;
    logic [7:0]  s_ca, s_pc;
    logic [15:0] s_ir, s_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_skip = 1'b1;
    bit         m_irv  = 1'b0;
    bit         m_err  = 1'b0;
    logic [15:0] m_ir  = 16'h0;
    logic [7:0]  m_stk [$];

    task automatic model_step();
        logic [3:0] op = instr[15:12];
        logic tk = 1'b0, rl = 1'b0, ps = 1'b0, pp = 1'b0, er = 1'b0, ld = 1'b0;
        logic [7:0] tg = 8'h00;
        if (res_n && !m_skip) begin
            case (op)
                4'hA: begin tk = 1'b1; tg = instr[7:0]; end
                4'hB: begin tk = 1'b1; rl = 1'b1; tg = instr[7:0]; end
                4'hC: if (flag_z) begin tk = 1'b1; rl = 1'b1; tg = instr[7:0]; end
                4'hD: if (flag_c) begin tk = 1'b1; rl = 1'b1; tg = instr[7:0]; end
                4'hE: begin tk = 1'b1; tg = instr[7:0]; ps = 1'b1; end
                4'hF: if (m_stk.size() > 0) begin tk = 1'b1; tg = m_stk[$]; pp = 1'b1; end
                      else er = 1'b1;
                default: ld = 1'b1;
            endcase
        end
        if (chk_en) begin
            chk("wr_en", wr_en, tk);
            chk("add_offset", add_offset, rl);
            chk("counteradress", counteradress, tg);
            chk("ir_valid", ir_valid, m_irv);
            chk("stack_err", stack_err, m_err);
            if (m_irv) chk("ir", ir, m_ir);
        end
        if (!res_n) begin
            m_skip = 1'b1;
            m_irv  = 1'b0;
            m_ir   = 16'h0;
            m_err  = 1'b0;
            m_stk.delete();
        end else begin
            if (ps) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    m_err = 1'b1;
                end
                m_stk.push_back(pc);
            end
            if (pp) void'(m_stk.pop_back());
            if (er) m_err = 1'b1;
            m_irv = ld;
            if (ld) m_ir = instr;
            m_skip = tk;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // ---------------- environment: PC register + synchronous program memory ----------------
    task automatic cycle();
        @(negedge clk);
        s_wr = wr_en; s_ao = add_offset; s_ca = counteradress;
        s_irv = ir_valid; s_err = stack_err; s_ir = ir; s_pc = pc; s_instr = instr;
        @(posedge clk);
        #1;
        if (!res_n) begin
            pc    = 8'hFF;
            instr = 16'hA055;
        end else begin
            instr = mem[pc];
            pc    = s_wr ? (s_ao ? pc + s_ca + 8'd1 : s_ca) : pc + 8'd1;
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[8'hFF] = 16'h0000;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        cycle();
        cycle();
        chk("rst_ir_valid", s_irv, 1'b0);
        chk("rst_stack_err", s_err, 1'b0);
        chk("rst_wr_en", s_wr, 1'b0);
        res_n = 1'b1;
    endtask

    task automatic wait_word(input logic [15:0] val);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (s_instr == val) found = 1'b1;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_%h: word not presented within 300 cycles", val);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ret_exp [4];

    initial begin
        init_mem();
        // Reset with a GOTO on instr: outputs and registers must stay quiet.
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_wr_en_goto", s_wr, 1'b0);
        chk("rst_ca", s_ca, 8'h00);
        chk("rst_ir", s_ir, 16'h0000);
        chk("rst_ir_valid", s_irv, 1'b0);
        chk("rst_stack_err", s_err, 1'b0);
        res_n = 1'b1;

        // Release: BOOT ignores the stale GOTO, pc steps FF->00.
        cycle();
        chk("boot_ignores", s_wr, 1'b0);
        cycle();
        chk("boot_slot_irv", s_irv, 1'b0);
        chk("pc_wrap", s_pc, 8'h00);
        cycle();
        chk("first_run_irv", s_irv, 1'b1);
        chk("first_run_ir", s_ir, 16'h0000);
        cycle();
        chk("second_run_ir", s_ir, 16'h1000);

        // GOTO 42 at address 10.
        mem[8'h10] = 16'hA042;
        wait_word(16'hA042);
        chk("goto_wr", s_wr, 1'b1);
        chk("goto_ca", s_ca, 8'h42);
        chk("goto_ao", s_ao, 1'b0);
        cycle();
        chk("goto_pc", s_pc, 8'h42);
        chk("goto_irv", s_irv, 1'b0);
        cycle();
        chk("goto_squash_irv", s_irv, 1'b0);
        cycle();
        chk("goto_target_ir", s_ir, 16'h1042);

        // BR -2 at address 20: loops onto itself; reset lands mid-squash.
        init_mem();
        do_reset();
        mem[8'h20] = 16'hB0FE;
        wait_word(16'hB0FE);
        chk("br_ao", s_ao, 1'b1);
        chk("br_ca", s_ca, 8'hFE);
        res_n = 1'b0;
        cycle();
        chk("br_pc", s_pc, 8'h20);

        // BRZ not taken (z=0), then BRC taken (c=1) right behind it.
        init_mem();
        flag_z = 1'b0;
        flag_c = 1'b1;
        do_reset();
        mem[8'h30] = 16'hC005;
        mem[8'h31] = 16'hD008;
        wait_word(16'hC005);
        chk("brz_nt_wr", s_wr, 1'b0);
        chk("brz_nt_ca", s_ca, 8'h00);
        cycle();
        chk("brz_slot_irv", s_irv, 1'b0);
        chk("brc_wr", s_wr, 1'b1);
        chk("brc_ca", s_ca, 8'h08);
        cycle();
        chk("brc_pc", s_pc, 8'h3B);
        cycle();
        cycle();
        chk("brc_target_ir", s_ir, 16'h103B);
        flag_c = 1'b0;

        // CALL 30 at 05, RET at 30 returns to 06, then RET at 07 finds it empty.
        init_mem();
        do_reset();
        mem[8'h05] = 16'hE030;
        mem[8'h30] = 16'hF000;
        mem[8'h07] = 16'hF000;
        wait_word(16'hE030);
        chk("call_wr", s_wr, 1'b1);
        chk("call_ca", s_ca, 8'h30);
        wait_word(16'hF000);
        chk("ret_ca", s_ca, 8'h06);
        chk("ret_wr", s_wr, 1'b1);
        cycle();
        chk("ret_no_err", s_err, 1'b0);
        wait_word(16'hF000);
        chk("ret_empty_wr", s_wr, 1'b0);
        chk("ret_empty_pc", s_pc, 8'h08);
        cycle();
        chk("ret_empty_err", s_err, 1'b1);

        // Reset just after a CALL must not retain the pushed entry.
        init_mem();
        do_reset();
        mem[8'h03] = 16'hE040;
        wait_word(16'hE040);
        res_n = 1'b0;
        cycle();
        do_reset();
        mem[8'h03] = 16'hF000;
        wait_word(16'hF000);
        chk("midcall_ret_wr", s_wr, 1'b0);
        cycle();
        chk("midcall_err", s_err, 1'b1);

        // Five nested CALLs overflow a 4-deep stack; RETs unwind what survives.
        init_mem();
        do_reset();
        mem[8'h10] = 16'hE020;
        mem[8'h20] = 16'hE030;
        mem[8'h30] = 16'hE040;
        mem[8'h40] = 16'hE050;
        mem[8'h50] = 16'hE060;
        mem[8'h60] = 16'hF000;
        mem[8'h51] = 16'hF000;
        mem[8'h41] = 16'hF000;
        mem[8'h31] = 16'hF000;
        mem[8'h21] = 16'hF000;
        mem[8'h22] = 16'hF000;
        wait_word(16'hE050);
        cycle();
        chk("four_calls_no_err", s_err, 1'b0);
        wait_word(16'hE060);
        cycle();
        chk("overflow_err", s_err, 1'b1);
        ret_exp[0] = 8'h51; ret_exp[1] = 8'h41; ret_exp[2] = 8'h31; ret_exp[3] = 8'h21;
        for (int k = 0; k < 4; k++) begin
            wait_word(16'hF000);
            chk("nested_ret_ca", s_ca, ret_exp[k]);
        end
        wait_word(16'hF000);
        chk("nested_ret_empty_wr", s_wr, 1'b0);
        chk("nested_ret_empty_pc", s_pc, 8'h22);
        wait_word(16'hF000);
        chk("nested_ret_last_wr", s_wr, 1'b0);
        cycle();
        chk("nested_err_sticky", s_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
